// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - arbitrates I-cache and D-cache block accesses onto one shared memory port.
// Define ARBITER_ROUND_ROBIN_EN to alternate contested grants; otherwise the D-cache always wins.
module memory_arbiter (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          ic_read_i,
    input  logic [27:0]   ic_address_i,
    output logic [127:0]  ic_readdata_o,
    output logic          ic_busywait_o,
    input  logic          dc_read_i,
    input  logic          dc_write_i,
    input  logic [27:0]   dc_address_i,
    input  logic [127:0]  dc_writedata_i,
    output logic [127:0]  dc_readdata_o,
    output logic          dc_busywait_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic [27:0]   mem_address_o,
    output logic [127:0]  mem_writedata_o,
    input  logic [127:0]  mem_readdata_i,
    input  logic          mem_busywait_i
);

    typedef enum logic [1:0] {
        IDLE,
        IC_ACCESS,
        DC_ACCESS,
        DONE
    } state_t;

    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_DC = 1'b1;

    state_t         state_q;
    logic           last_grant_q;
    logic           mem_read_q;
    logic           mem_write_q;
    logic [27:0]    mem_address_q;
    logic [127:0]   mem_writedata_q;
    logic [127:0]   ic_readdata_q;
    logic [127:0]   dc_readdata_q;

    logic           ic_req;
    logic           dc_req;
    logic           grant_dc_d;

    always_comb begin
        ic_req = ic_read_i;
        dc_req = dc_read_i | dc_write_i;
`ifdef ARBITER_ROUND_ROBIN_EN
        // On contention the requester that did not win last time gets the port.
        grant_dc_d = dc_req && (!ic_req || (last_grant_q == GRANT_IC));
`else
        grant_dc_d = dc_req;
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            last_grant_q    <= GRANT_IC;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            ic_readdata_q   <= '0;
            dc_readdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_dc_d) begin
                        state_q         <= DC_ACCESS;
                        last_grant_q    <= GRANT_DC;
                        mem_address_q   <= dc_address_i;
                        mem_writedata_q <= dc_writedata_i;
                        // A simultaneous read and write request is served as a write-back.
                        mem_write_q     <= dc_write_i;
                        mem_read_q      <= ~dc_write_i;
                    end else if (ic_req) begin
                        state_q         <= IC_ACCESS;
                        last_grant_q    <= GRANT_IC;
                        mem_address_q   <= ic_address_i;
                        mem_writedata_q <= '0;
                        mem_write_q     <= 1'b0;
                        mem_read_q      <= 1'b1;
                    end
                end
                IC_ACCESS, DC_ACCESS: begin
                    if (!mem_busywait_i) begin
                        if (mem_read_q) begin
                            if (state_q == IC_ACCESS) begin
                                ic_readdata_q <= mem_readdata_i;
                            end else begin
                                dc_readdata_q <= mem_readdata_i;
                            end
                        end
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Each stall is released only in the single DONE cycle of that requester's own access.
    assign ic_busywait_o = ic_req && !((state_q == DONE) && (last_grant_q == GRANT_IC));
    assign dc_busywait_o = dc_req && !((state_q == DONE) && (last_grant_q == GRANT_DC));

    assign ic_readdata_o   = ic_readdata_q;
    assign dc_readdata_o   = dc_readdata_q;
    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign mem_address_o   = mem_address_q;
    assign mem_writedata_o = mem_writedata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter: directed vectors plus randomized model comparison.
module tb_memory_arbiter;

`ifdef ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [27:0]  IC_A = 28'h0000010;
    localparam logic [27:0]  DC_A = 28'h0000020;
    localparam logic [127:0] WD   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [127:0] A5   = {16{8'hA5}};
    localparam logic [127:0] D5A  = {16{8'h5A}};
    localparam logic [127:0] D77  = {16{8'h77}};

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_read;
    logic [27:0]  ic_address;
    logic [127:0] ic_readdata;
    logic         ic_busywait;
    logic         dc_read;
    logic         dc_write;
    logic [27:0]  dc_address;
    logic [127:0] dc_writedata;
    logic [127:0] dc_readdata;
    logic         dc_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    memory_arbiter dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .ic_read_i       (ic_read),
        .ic_address_i    (ic_address),
        .ic_readdata_o   (ic_readdata),
        .ic_busywait_o   (ic_busywait),
        .dc_read_i       (dc_read),
        .dc_write_i      (dc_write),
        .dc_address_i    (dc_address),
        .dc_writedata_i  (dc_writedata),
        .dc_readdata_o   (dc_readdata),
        .dc_busywait_o   (dc_busywait),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_address_o   (mem_address),
        .mem_writedata_o (mem_writedata),
        .mem_readdata_i  (mem_readdata),
        .mem_busywait_i  (mem_busywait)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit ic, dcr, dcw, busy;
        bit e_rd, e_wr, e_icbw, e_dcbw;
    } vec_t;
    vec_t vt[20];

    // Reference memory and transaction-level model state
    logic [127:0] mem [logic [27:0]];
    int           edge_n, m_done_edge, m_next_free, m_w;
    bit           m_active, m_in_done, m_owner, m_last, m_is_write, pick;
    logic [27:0]  m_addr;
    logic [127:0] m_data, m_ic_rd, m_dc_rd;

    function automatic logic [127:0] mem_rd(input logic [27:0] a);
        if (mem.exists(a)) return mem[a];
        return {4{32'hC0DE_0000 ^ {4'h0, a}}};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_dc_done(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (!dc_busywait) ok = 1'b1;
        end
        chk(nm, ok, 1'b1);
    endtask

    task automatic new_dc_req();
        int op;
        op = $urandom_range(0, 2);
        dc_read      = (op != 1);
        dc_write     = (op != 0);
        dc_address   = 28'($urandom_range(0, 7));
        dc_writedata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int got;
        logic [27:0] exp_a;

        vt[0]  = '{1,0,0,1, 0,0,1,0};
        vt[1]  = '{1,0,0,1, 1,0,1,0};
        vt[2]  = '{1,0,0,1, 1,0,1,0};
        vt[3]  = '{1,0,0,1, 1,0,1,0};
        vt[4]  = '{1,0,0,1, 1,0,1,0};
        vt[5]  = '{1,0,0,0, 1,0,1,0};
        vt[6]  = '{1,0,0,1, 0,0,0,0};
        vt[7]  = '{0,0,0,1, 0,0,0,0};
        vt[8]  = '{1,0,1,0, 0,0,1,1};
        vt[9]  = '{1,0,1,0, 0,1,1,1};
        vt[10] = '{1,0,1,0, 0,0,1,0};
        vt[11] = '{1,0,0,0, 0,0,1,0};
        vt[12] = '{1,0,0,0, 1,0,1,0};
        vt[13] = '{1,0,0,0, 0,0,0,0};
        vt[14] = '{0,0,0,0, 0,0,0,0};
        vt[15] = '{0,1,1,1, 0,0,0,1};
        vt[16] = '{0,1,1,1, 0,1,0,1};
        vt[17] = '{0,1,1,0, 0,1,0,1};
        vt[18] = '{0,1,1,0, 0,0,0,0};
        vt[19] = '{0,0,0,0, 0,0,0,0};

        rst = 1'b1;
        ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
        ic_address = IC_A; dc_address = DC_A; dc_writedata = WD;
        mem_readdata = A5; mem_busywait = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset mem_read", mem_read, 1'b0);
        chk("reset mem_write", mem_write, 1'b0);
        chk("reset mem_address", mem_address, 28'h0);
        chk("reset mem_writedata", mem_writedata, 128'h0);
        chk("reset ic_readdata", ic_readdata, 128'h0);
        chk("reset dc_readdata", dc_readdata, 128'h0);
        chk("reset ic_busywait", ic_busywait, 1'b0);
        chk("reset dc_busywait", dc_busywait, 1'b0);
        rst = 1'b0;

        // Wait-state read, contested grant, read+write write-back
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ic_read = vt[i].ic; dc_read = vt[i].dcr; dc_write = vt[i].dcw;
            mem_busywait = vt[i].busy;
            #1;
            chk($sformatf("row%0d mem_read", i), mem_read, vt[i].e_rd);
            chk($sformatf("row%0d mem_write", i), mem_write, vt[i].e_wr);
            chk($sformatf("row%0d ic_busywait", i), ic_busywait, vt[i].e_icbw);
            chk($sformatf("row%0d dc_busywait", i), dc_busywait, vt[i].e_dcbw);
            if (vt[i].e_rd || vt[i].e_wr)
                chk($sformatf("row%0d mem_address", i), mem_address, vt[i].e_wr ? DC_A : IC_A);
            if (vt[i].e_wr)
                chk($sformatf("row%0d mem_writedata", i), mem_writedata, WD);
            if (i == 6)
                chk("ic_readdata after wait read", ic_readdata, A5);
        end
        chk("dc_readdata unchanged by write", dc_readdata, 128'h0);

        // Reset in the middle of a DC read
        @(negedge clk);
        dc_address = 28'h0000030; dc_read = 1'b1; mem_busywait = 1'b0; mem_readdata = D5A;
        wait_dc_done("dc first read done");
        chk("dc first read data", dc_readdata, D5A);
        dc_read = 1'b0;
        @(negedge clk);
        dc_read = 1'b1; mem_busywait = 1'b1; mem_readdata = D77;
        @(negedge clk);
        #1;
        chk("pre-reset strobe", mem_read, 1'b1);
        rst = 1'b1;
        #1;
        chk("async reset mem_read", mem_read, 1'b0);
        chk("async reset mem_address", mem_address, 28'h0);
        chk("async reset dc_readdata", dc_readdata, 128'h0);
        chk("async reset dc_busywait", dc_busywait, 1'b1);
        mem_busywait = 1'b0;
        @(negedge clk);
        #1;
        chk("held reset mem_read", mem_read, 1'b0);
        chk("held reset no capture", dc_readdata, 128'h0);
        rst = 1'b0;
        wait_dc_done("re-served after reset");
        chk("re-served data", dc_readdata, D77);
        dc_read = 1'b0;

        // Both requesters held high with zero-wait memory
        do_reset();
        ic_address = IC_A; dc_address = DC_A;
        ic_read = 1'b1; dc_read = 1'b1; dc_write = 1'b0; mem_busywait = 1'b0;
        got = 0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            @(negedge clk);
            #1;
            if (mem_read) begin
                exp_a = (RR && (got % 2 == 1)) ? IC_A : DC_A;
                chk($sformatf("held grant %0d", got), mem_address, exp_a);
                got++;
            end
        end
        chk("held grant count", got, 4);
        ic_read = 1'b0; dc_read = 1'b0;

        // Randomized traffic against the transaction model
        do_reset();
        edge_n = 0; m_next_free = 0; m_done_edge = 0;
        m_active = 0; m_in_done = 0; m_owner = 0; m_last = 0; m_is_write = 0;
        m_ic_rd = '0; m_dc_rd = '0; m_addr = '0; m_data = '0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            edge_n++;
            m_in_done = 0;
            if (m_active && edge_n == m_done_edge) begin
                if (m_is_write) mem[m_addr] = m_data;
                else if (m_owner) m_dc_rd = mem_rd(m_addr);
                else m_ic_rd = mem_rd(m_addr);
                m_active = 0;
                m_in_done = 1;
            end else if (!m_active && edge_n >= m_next_free && (ic_read || dc_read || dc_write)) begin
                pick = (dc_read || dc_write) && (!ic_read || !RR || m_last == 0);
                m_owner = pick; m_last = pick;
                m_is_write = pick && dc_write;
                m_addr = pick ? dc_address : ic_address;
                m_data = dc_writedata;
                m_w = $urandom_range(0, 3);
                m_done_edge = edge_n + m_w + 1;
                m_next_free = edge_n + m_w + 3;
                m_active = 1;
            end
            @(negedge clk);
            #1;
            chk($sformatf("rnd%0d mem_read", c), mem_read, m_active && !m_is_write);
            chk($sformatf("rnd%0d mem_write", c), mem_write, m_active && m_is_write);
            if (m_active) chk($sformatf("rnd%0d mem_address", c), mem_address, m_addr);
            if (m_active && m_is_write) chk($sformatf("rnd%0d mem_writedata", c), mem_writedata, m_data);
            chk($sformatf("rnd%0d ic_busywait", c), ic_busywait, ic_read && !(m_in_done && m_owner == 0));
            chk($sformatf("rnd%0d dc_busywait", c), dc_busywait, (dc_read || dc_write) && !(m_in_done && m_owner == 1));
            chk($sformatf("rnd%0d ic_readdata", c), ic_readdata, m_ic_rd);
            chk($sformatf("rnd%0d dc_readdata", c), dc_readdata, m_dc_rd);

            if (m_active) begin
                mem_busywait = (edge_n + 1 != m_done_edge);
                mem_readdata = mem_rd(m_addr);
            end else begin
                mem_busywait = 1'($urandom_range(0, 1));
                mem_readdata = {$urandom, $urandom, $urandom, $urandom};
            end

            if (m_in_done && m_owner == 0) begin
                ic_read = ($urandom_range(0, 2) == 0);
                ic_address = 28'($urandom_range(0, 7));
            end else if (!ic_read && $urandom_range(0, 2) == 0) begin
                ic_read = 1'b1;
                ic_address = 28'($urandom_range(0, 7));
            end else if (ic_read && !(m_active && m_owner == 0) && $urandom_range(0, 15) == 0) begin
                ic_read = 1'b0;
            end

            if (m_in_done && m_owner == 1) begin
                dc_read = 1'b0; dc_write = 1'b0;
                if ($urandom_range(0, 2) == 0) new_dc_req();
            end else if (!dc_read && !dc_write && $urandom_range(0, 2) == 0) begin
                new_dc_req();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL use one clock, CLK; RESET is asynchronous and active-high.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  asynchronous active-high reset.
REQ-004 IC_READ  input  1  instruction-cache block read request.
REQ-005 IC_ADDRESS  input  28  instruction block address.
REQ-006 IC_READDATA  output  128  block returned to instruction cache, registered.
REQ-007 IC_BUSYWAIT  output  1  instruction cache stall.
REQ-008 DC_READ  input  1  data-cache block read request.
REQ-009 DC_WRITE  input  1  data-cache block write-back request.
REQ-010 DC_ADDRESS  input  28  data block address.
REQ-011 DC_WRITEDATA  input  128  write-back block.
REQ-012 DC_READDATA  output  128  block returned to data cache, registered.
REQ-013 DC_BUSYWAIT  output  1  data cache stall.
REQ-014 MEM_READ / MEM_WRITE  output  1 each  shared main-memory strobes, registered.
REQ-015 MEM_ADDRESS  output  28  registered.
REQ-016 MEM_WRITEDATA  output  128  registered.
REQ-017 MEM_READDATA  input  128  memory read block.
REQ-018 MEM_BUSYWAIT  input  1  memory stall; low during the final cycle of an access.

Function
REQ-019 FSM states SHALL be IDLE, IC_ACCESS, DC_ACCESS, DONE.
REQ-020 IDLE: requests are sampled at the posedge. DC request (DC_READ|DC_WRITE) -> DC_ACCESS. IC_READ only -> IC_ACCESS. No request -> stay in IDLE.
REQ-021 On entry to X_ACCESS, MEM_ADDRESS, MEM_WRITEDATA and the strobes SHALL be loaded from requester X. Strobes are held until the posedge that exits X_ACCESS.
REQ-022 If DC_READ and DC_WRITE are both high, the access SHALL be a write (MEM_WRITE=1, MEM_READ=0).
REQ-023 X_ACCESS SHALL exit to DONE at the first posedge with MEM_BUSYWAIT=0. On a read, MEM_READDATA is captured into X_READDATA at that edge. Strobes clear at that edge.
REQ-024 DONE SHALL last exactly one cycle with no memory strobes, then go to IDLE. No arbitration occurs in DONE.
REQ-025 X_BUSYWAIT SHALL equal (X request asserted) AND NOT (state==DONE AND last grant==X), combinationally.
REQ-026 X_READDATA SHALL hold its value until the next completed read for X.
REQ-027 Minimum service time SHALL be 3 posedges: grant, complete, DONE. The next grant comes no earlier than the posedge after DONE.
REQ-028 Requester inputs SHALL be ignored outside IDLE. The memory sees only the granted requester's address and data.
REQ-029 A request withdrawn while not granted SHALL have no effect.

Reset
REQ-030 While RESET is high, the block SHALL force state=IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, IC_READDATA=0, DC_READDATA=0, last grant=IC, immediately and without waiting for CLK.
REQ-031 Reset mid-access SHALL abort the access with no data capture. Busywaits SHALL then follow the requests per REQ-025.
REQ-032 The first posedge after RESET falls SHALL arbitrate normally from IDLE.

Configuration
REQ-033 With ARBITER_ROUND_ROBIN_EN defined, a simultaneous IC and DC request in IDLE SHALL be granted to the requester not granted last. Without the macro, DC always wins per REQ-020. Uncontested grants are identical in both builds.

Verification
REQ-034 IC_READ at 0x0000010, memory with 4 wait cycles returning 0xA5..A5 -> MEM_READ high for 5 cycles, IC_READDATA=0xA5..A5, IC_BUSYWAIT low only in DONE.
REQ-035 DC_WRITE at 0x0000020 with data 0x1234.. and IC_READ raised at the same edge -> DC served first, then IC granted the posedge after DONE (fixed-priority build).
REQ-036 With ARBITER_ROUND_ROBIN_EN, IC and DC held continuously high -> grants alternate DC, IC, DC, IC.
REQ-037 DC_READ and DC_WRITE both high -> MEM_WRITE=1, MEM_READ=0, DC_READDATA unchanged.
REQ-038 RESET pulsed mid DC_ACCESS -> strobes 0 before next posedge, DC_READDATA=0, DC_BUSYWAIT stays high while DC_READ stays high, then re-served.
REQ-039 Memory with 0 wait cycles (MEM_BUSYWAIT never high) -> access completes in one ACCESS cycle, 3-cycle turnaround per REQ-027.
